// File: rtl/gf180_ram_128x8_arbiter.sv
// Round-robin two-port arbiter for a gf180 128x8 SRAM macro, with active-low macro control conversion.
// Define GF180_RAM_ARB_CLEAR_EN to zero the whole array after reset before any request is granted.
module gf180_ram_128x8_arbiter (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       WE0,
    input  logic       WE1,
    input  logic [6:0] ADDR0,
    input  logic [6:0] ADDR1,
    input  logic [7:0] WDATA0,
    input  logic [7:0] WDATA1,
    input  logic [7:0] WMASK0,
    input  logic [7:0] WMASK1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       RVALID0,
    output logic       RVALID1,
    output logic [7:0] RDATA0,
    output logic [7:0] RDATA1,
    output logic       INIT_DONE,
    output logic       RAM_CEN,
    output logic       RAM_GWEN,
    output logic [6:0] RAM_A,
    output logic [7:0] RAM_D,
    output logic [7:0] RAM_WEN,
    input  logic [7:0] RAM_Q
);

    logic       prio;
    logic       init_done;
    logic       clearing;
    logic [6:0] clr_addr;
    logic       gnt0, gnt1;
    logic       rvalid0, rvalid1;

`ifdef GF180_RAM_ARB_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t     state;
    logic [6:0] clr_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_CLEAR;
            clr_cnt   <= 7'd0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 7'd1;
                    if (clr_cnt == 7'd127) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                default: init_done <= 1'b1;
            endcase
        end
    end

    // Gated by RST_N so the macro sees idle controls while reset is held.
    assign clearing = (state == ST_CLEAR) && RST_N;
    assign clr_addr = clr_cnt;
`else
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) init_done <= 1'b0;
        else        init_done <= 1'b1;
    end

    assign clearing = 1'b0;
    assign clr_addr = 7'd0;
`endif

    // prio names the port that wins when both request.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (init_done) begin
            if (REQ0 && (!REQ1 || !prio)) gnt0 = 1'b1;
            else if (REQ1)                gnt1 = 1'b1;
        end
    end

    always_comb begin
        RAM_CEN  = 1'b1;
        RAM_GWEN = 1'b1;
        RAM_WEN  = 8'hFF;
        RAM_A    = 7'd0;
        RAM_D    = 8'h00;
        if (clearing) begin
            RAM_CEN  = 1'b0;
            RAM_GWEN = 1'b0;
            RAM_WEN  = 8'h00;
            RAM_A    = clr_addr;
        end else if (gnt0) begin
            RAM_CEN  = 1'b0;
            RAM_GWEN = ~WE0;
            RAM_WEN  = WE0 ? ~WMASK0 : 8'hFF;
            RAM_A    = ADDR0;
            RAM_D    = WDATA0;
        end else if (gnt1) begin
            RAM_CEN  = 1'b0;
            RAM_GWEN = ~WE1;
            RAM_WEN  = WE1 ? ~WMASK1 : 8'hFF;
            RAM_A    = ADDR1;
            RAM_D    = WDATA1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prio    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~WE0;
            rvalid1 <= gnt1 & ~WE1;
            if (gnt0)      prio <= 1'b1;
            else if (gnt1) prio <= 1'b0;
        end
    end

    assign GNT0      = gnt0;
    assign GNT1      = gnt1;
    assign RVALID0   = rvalid0;
    assign RVALID1   = rvalid1;
    assign RDATA0    = rvalid0 ? RAM_Q : 8'h00;
    assign RDATA1    = rvalid1 ? RAM_Q : 8'h00;
    assign INIT_DONE = init_done;

endmodule
